// File: rtl/neuron_pkg.sv
// Shared constants and state encoding for the neuron layer sequencer.
package neuron_pkg;

    localparam int DEF_WEIGHT_W   = 8;
    localparam int DEF_LATENCY    = 7;
    localparam int DEF_LOAD_DEPTH = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/neuron_layer_ctrl.sv
// Sequencer for neuron_layer: streams weights onto its programming bus and
// runs single-vector inferences, holding layer_in for the pipeline depth.
module neuron_layer_ctrl
    import neuron_pkg::*;
#(
    parameter int SIZE       = 32,
    parameter int WEIGHT_W   = DEF_WEIGHT_W,
    parameter int LOAD_DEPTH = DEF_LOAD_DEPTH,
    parameter int ADDR_W     = 5,
    parameter int LATENCY    = DEF_LATENCY
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_start,
    input  logic                wt_valid,
    input  logic [WEIGHT_W-1:0] wt_data,
    output logic                wt_ready,
    input  logic                inf_valid,
    input  logic [SIZE-1:0]     inf_data,
    output logic                inf_ready,
    output logic                res_valid,
    output logic                res_data,
    input  logic                res_ready,
    output logic                load_done,
    output logic                busy,
    output logic                layer_swr,
    output logic [ADDR_W-1:0]   layer_set_addr,
    output logic [WEIGHT_W-1:0] layer_set_weight,
    output logic [SIZE-1:0]     layer_in,
    input  logic                layer_out
);

    localparam int LAT_W = $clog2(LATENCY) + 1;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr_cnt;
    logic [LAT_W-1:0]  lat_cnt;
    logic              last_beat;
    logic              lat_done;

    assign last_beat = wt_valid && (addr_cnt == ADDR_W'(LOAD_DEPTH - 1));
    assign lat_done  = (lat_cnt == LAT_W'(LATENCY - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (cfg_start)      state_nxt = S_LOAD;
                else if (inf_valid) state_nxt = S_RUN;
            end
            S_LOAD:  if (last_beat) state_nxt = S_IDLE;
            S_RUN:   if (lat_done)  state_nxt = S_DONE;
            S_DONE:  if (res_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // A simultaneous cfg_start steals the cycle, so the vector must not look accepted.
    always_comb begin
        wt_ready  = (state == S_LOAD);
        inf_ready = (state == S_IDLE) && !cfg_start;
        busy      = (state != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_cnt         <= '0;
            lat_cnt          <= '0;
            layer_swr        <= 1'b0;
            layer_set_addr   <= '0;
            layer_set_weight <= '0;
            layer_in         <= '0;
            load_done        <= 1'b0;
            res_valid        <= 1'b0;
            res_data         <= 1'b0;
        end else begin
            layer_swr <= 1'b0;
            load_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cfg_start) begin
                        addr_cnt <= '0;
                    end else if (inf_valid) begin
                        layer_in <= inf_data;
                        lat_cnt  <= '0;
                    end
                end
                S_LOAD: begin
                    if (wt_valid) begin
                        layer_swr        <= 1'b1;
                        layer_set_addr   <= addr_cnt;
                        layer_set_weight <= wt_data;
                        // Counter parks on the last address instead of wrapping.
                        if (last_beat) load_done <= 1'b1;
                        else           addr_cnt  <= addr_cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    lat_cnt <= lat_cnt + 1'b1;
                    if (lat_done) begin
                        res_data  <= layer_out;
                        res_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (res_ready) res_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_layer_ctrl.sv
// Directed bench for neuron_layer_ctrl with a behavioural neuron_layer stand-in
// and scoreboards for weight writes and inference results.
module tb_neuron_layer_ctrl;

    localparam int SIZE = 32;
    localparam int WW   = 8;
    localparam int AW   = 5;
    localparam int LAT  = 7;
    localparam int DEP  = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            cfg_start, wt_valid, wt_ready;
    logic [WW-1:0]   wt_data;
    logic            inf_valid, inf_ready;
    logic [SIZE-1:0] inf_data;
    logic            res_valid, res_data, res_ready;
    logic            load_done, busy, layer_swr, layer_out;
    logic [AW-1:0]   layer_set_addr;
    logic [WW-1:0]   layer_set_weight;
    logic [SIZE-1:0] layer_in;

    int checks   = 0;
    int failures = 0;

    logic [AW+WW-1:0] wr_q[$];
    logic             res_q[$];
    logic [SIZE-1:0]  exp_mask = '0;
    logic [SIZE-1:0]  lay_mask = '0;
    logic [5:0]       lay_pipe = '0;
    int               tb_addr  = 0;

    neuron_layer_ctrl #(
        .SIZE(SIZE), .WEIGHT_W(WW), .LOAD_DEPTH(DEP), .ADDR_W(AW), .LATENCY(LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start),
        .wt_valid(wt_valid), .wt_data(wt_data), .wt_ready(wt_ready),
        .inf_valid(inf_valid), .inf_data(inf_data), .inf_ready(inf_ready),
        .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
        .load_done(load_done), .busy(busy), .layer_swr(layer_swr),
        .layer_set_addr(layer_set_addr), .layer_set_weight(layer_set_weight),
        .layer_in(layer_in), .layer_out(layer_out)
    );

    always #5 clk = ~clk;

    // Layer stand-in: bit i of the input contributes when weight i has odd parity;
    // result travels six register stages, so it is only valid on the seventh edge.
    always @(posedge clk) begin
        if (layer_swr) lay_mask[layer_set_addr] <= ^layer_set_weight;
        lay_pipe <= {lay_pipe[4:0], ^(layer_in & lay_mask)};
    end
    assign layer_out = lay_pipe[5];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then compare any write the DUT issued against the scoreboard.
    task automatic tick();
        logic [AW+WW-1:0] e;
        @(posedge clk);
        #1;
        if (layer_swr) begin
            if (wr_q.size() == 0) chk("unexpected_swr", 1, 0);
            else begin
                e = wr_q.pop_front();
                chk("write", {layer_set_addr, layer_set_weight}, e);
            end
        end
    endtask

    task automatic push_beat(input logic [WW-1:0] d);
        wt_valid = 1'b1;
        wt_data  = d;
        wr_q.push_back({AW'(tb_addr), d});
        exp_mask[tb_addr] = ^d;
        tb_addr++;
    endtask

    task automatic full_load(input bit bubbles, input int mult);
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        tb_addr   = 0;
        chk("load_wt_ready", wt_ready, 1);
        for (int i = 0; i < DEP; i++) begin
            push_beat(WW'(i * mult + 1));
            tick();
            chk("load_swr", layer_swr, 1);
            chk("load_done_pulse", load_done, (i == DEP - 1) ? 1 : 0);
            if (bubbles && i != DEP - 1) begin
                wt_valid = 1'b0;
                tick();
                chk("bubble_swr", layer_swr, 0);
                chk("bubble_addr", layer_set_addr, i);
            end
        end
        wt_valid = 1'b0;
        chk("load_wq_empty", wr_q.size(), 0);
        tick();
        chk("load_busy_after", busy, 0);
        chk("load_done_one_cycle", load_done, 0);
    endtask

    task automatic infer(input logic [SIZE-1:0] d, input int stall);
        int n;
        logic e;
        inf_valid = 1'b1;
        inf_data  = d;
        res_q.push_back(^(d & exp_mask));
        tick();
        inf_valid = 1'b0;
        chk("inf_busy", busy, 1);
        chk("inf_layer_in", layer_in, d);
        n = 0;
        while (!res_valid && n < 20) begin
            tick();
            n++;
        end
        chk("inf_latency", n, LAT);
        e = res_q.pop_front();
        chk("inf_res_data", res_data, e);
        for (int k = 0; k < stall; k++) begin
            inf_valid = 1'b1;
            inf_data  = ~d;
            tick();
            chk("stall_res_valid", res_valid, 1);
            chk("stall_res_data", res_data, e);
            chk("stall_inf_ready", inf_ready, 0);
            chk("stall_layer_in", layer_in, d);
        end
        inf_valid = 1'b0;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("res_drop", res_valid, 0);
        chk("res_idle", busy, 0);
        chk("res_layer_in_hold", layer_in, d);
    endtask

    initial begin
        rst_n     = 1'b0;
        cfg_start = 1'b0;
        wt_valid  = 1'b0;
        wt_data   = '0;
        inf_valid = 1'b0;
        inf_data  = '0;
        res_ready = 1'b0;
        #12;
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_load_done", load_done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_swr", layer_swr, 0);
        chk("rst_addr", layer_set_addr, 0);
        chk("rst_weight", layer_set_weight, 0);
        chk("rst_layer_in", layer_in, 0);
        chk("rst_wt_ready", wt_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Partial load of 10 beats, then asynchronous reset mid-load.
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        tb_addr   = 0;
        for (int i = 0; i < 10; i++) begin
            push_beat(WW'(i + 1));
            tick();
        end
        chk("partial_addr", layer_set_addr, 9);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_swr", layer_swr, 0);
        chk("midrst_addr", layer_set_addr, 0);
        chk("midrst_weight", layer_set_weight, 0);
        chk("midrst_wt_ready", wt_ready, 0);
        chk("midrst_wq", wr_q.size(), 0);
        wt_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back reload from address 0, weights 0x01..0x20.
        full_load(1'b0, 1);
        infer(32'hFFFF_FFFF, 5);
        infer(32'h0000_0003, 0);

        // Load with a bubble between every beat, different weights.
        full_load(1'b1, 3);
        infer(32'h0000_0005, 0);
        infer(32'h8000_0102, 2);

        // cfg_start and inf_valid together: load wins, vector ignored.
        cfg_start = 1'b1;
        inf_valid = 1'b1;
        inf_data  = 32'h1234_5678;
        #1;
        chk("collide_inf_ready", inf_ready, 0);
        tick();
        cfg_start = 1'b0;
        chk("collide_load", wt_ready, 1);
        chk("collide_inf_ready_load", inf_ready, 0);
        chk("collide_layer_in", layer_in, 32'h8000_0102);
        inf_valid = 1'b0;
        tb_addr   = 0;
        for (int i = 0; i < DEP; i++) begin
            push_beat(WW'(i + 1));
            tick();
        end
        wt_valid = 1'b0;
        tick();
        chk("collide_load_complete", busy, 0);
        chk("final_wq_empty", wr_q.size(), 0);
        chk("final_rq_empty", res_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
